// File: rtl/bcd_scan_ctrl.sv
// Binary-to-BCD converter (shift-and-add-3, one bit per cycle) feeding a
// three-digit multiplexed display scanner with optional leading-zero blanking.
module bcd_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter logic        BLANK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       digit_blank
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q;
  logic [7:0]  sr_q;
  logic [11:0] work_q;
  logic [2:0]  cnt_q;
  logic [3:0]  hund_q, tens_q, ones_q;
  logic        done_q;
  logic [15:0] div_q;
  logic [1:0]  idx_q;

  logic [11:0] work_adj;
  logic [11:0] work_d;
  logic [7:0]  sr_d;

  // Add-3 correction on every digit >= 5, then shift {work, sr} left by one.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < 3; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    work_d = {work_adj[10:0], sr_q[7]};
    sr_d   = {sr_q[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q    <= in_data;
            work_q  <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q   <= sr_d;
          work_q <= work_d;
          cnt_q  <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          hund_q  <= work_q[11:8];
          tens_q  <= work_q[7:4];
          ones_q  <= work_q[3:0];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Scan timing runs freely, decoupled from conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == SCAN_DIV - 16'd1) begin
      div_q <= '0;
      idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q != IDLE) && !rst;
  assign done     = done_q && !rst;

  always_comb begin
    digit_sel   = 3'b001;
    digit_val   = ones_q;
    digit_blank = 1'b0;
    case (idx_q)
      2'd1: begin
        digit_sel   = 3'b010;
        digit_val   = tens_q;
        digit_blank = BLANK_EN && (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        digit_sel   = 3'b100;
        digit_val   = hund_q;
        digit_blank = BLANK_EN && (hund_q == 4'd0);
      end
      default: ;
    endcase
    if (rst) begin
      digit_sel   = 3'b001;
      digit_val   = 4'd0;
      digit_blank = 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl: a SCAN_DIV=4 blanking instance and a SCAN_DIV=1
// non-blanking instance share stimulus; expectations come from divide/modulo.
module tb_bcd_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic       in_ready, busy, done, digit_blank;
  logic [2:0] digit_sel;
  logic [3:0] digit_val;
  logic       b_in_ready, b_busy, b_done, b_digit_blank;
  logic [2:0] b_digit_sel;
  logic [3:0] b_digit_val;

  bcd_scan_ctrl #(.SCAN_DIV(16'd4), .BLANK_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done),
    .digit_sel(digit_sel), .digit_val(digit_val), .digit_blank(digit_blank)
  );

  bcd_scan_ctrl #(.SCAN_DIV(16'd1), .BLANK_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .busy(b_busy), .done(b_done),
    .digit_sel(b_digit_sel), .digit_val(b_digit_val), .digit_blank(b_digit_blank)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] cap_val[3];
  logic       cap_blank[3];
  logic [3:0] cap2_val[3];
  int         cap2_blank_cnt;
  int         cap_bad_sel;
  int         cap_done_cnt;

  // d: 0 ones, 1 tens, 2 hundreds
  function automatic logic [3:0] ref_digit(input int v, input int d);
    int p;
    p = (d == 0) ? 1 : (d == 1) ? 10 : 100;
    return 4'((v / p) % 10);
  endfunction

  function automatic logic ref_blank(input int v, input int d);
    if (d == 2) return v < 100;
    if (d == 1) return v < 10;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int d = 0; d < 3; d++) begin
      cap_val[d] = 'x; cap_blank[d] = 1'bx; cap2_val[d] = 'x;
    end
    cap2_blank_cnt = 0; cap_bad_sel = 0; cap_done_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      case (digit_sel)
        3'b001: begin cap_val[0] = digit_val; cap_blank[0] = digit_blank; end
        3'b010: begin cap_val[1] = digit_val; cap_blank[1] = digit_blank; end
        3'b100: begin cap_val[2] = digit_val; cap_blank[2] = digit_blank; end
        default: cap_bad_sel++;
      endcase
      case (b_digit_sel)
        3'b001: cap2_val[0] = b_digit_val;
        3'b010: cap2_val[1] = b_digit_val;
        3'b100: cap2_val[2] = b_digit_val;
        default: cap_bad_sel++;
      endcase
      if (b_digit_blank !== 1'b0) cap2_blank_cnt++;
      if (done !== 1'b0 || b_done !== 1'b0) cap_done_cnt++;
    end
  endtask

  // Drives one value; optional random in_valid/in_data noise while busy.
  task automatic convert(input logic [7:0] v, input bit noise,
                         output int lat, output int bad, output bit rdy_after);
    int w;
    lat = 0; bad = 0; rdy_after = 0; w = 0;
    tick();
    in_valid = 1'b1; in_data = v;
    while (w < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      w++;
    end
    if (w == 50) bad++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = k; break; end
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    rdy_after = (in_ready === 1'b1) && (busy === 1'b0) && (done === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd77;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_checks++; if (digit_sel !== 3'b001 || b_digit_sel !== 3'b001) begin n_fail++; $display("FAIL reset_sel: got %b/%b want 001", digit_sel, b_digit_sel); end
    n_checks++; if (digit_val !== 4'd0 || digit_blank !== 1'b0) begin n_fail++; $display("FAIL reset_val_blank: got %0d/%b want 0/0", digit_val, digit_blank); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_priority_idle: ready=%b busy=%b want 1/0", in_ready, busy); end
  endtask

  task automatic check_display(input string name, input int v);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (cap_val[d] !== ref_digit(v, d) || cap_blank[d] !== ref_blank(v, d)) begin
        n_fail++;
        $display("FAIL %s_digit%0d v=%0d: got val=%0d blank=%b want val=%0d blank=%b",
                 name, d, v, cap_val[d], cap_blank[d], ref_digit(v, d), ref_blank(v, d));
      end
      n_checks++;
      if (cap2_val[d] !== ref_digit(v, d)) begin
        n_fail++;
        $display("FAIL %s_b_digit%0d v=%0d: got %0d want %0d", name, d, v, cap2_val[d], ref_digit(v, d));
      end
    end
    n_checks++;
    if (cap2_blank_cnt != 0 || cap_bad_sel != 0) begin
      n_fail++;
      $display("FAIL %s_noblank_sel: blank_cycles=%0d bad_sel=%0d want 0/0", name, cap2_blank_cnt, cap_bad_sel);
    end
  endtask

  task automatic test_max();
    int lat, bad; bit rdy;
    convert(8'd255, 1'b0, lat, bad, rdy);
    n_checks++; if (lat != 9) begin n_fail++; $display("FAIL max_latency: got %0d want 9", lat); end
    n_checks++; if (bad != 0 || !rdy) begin n_fail++; $display("FAIL max_handshake: bad=%0d ready_after=%b want 0/1", bad, rdy); end
    capture(12);
    check_display("max", 255);
  endtask

  task automatic test_zero_blank();
    int lat, bad; bit rdy;
    convert(8'd0, 1'b0, lat, bad, rdy);
    capture(12);
    check_display("zero", 0);
    convert(8'd105, 1'b0, lat, bad, rdy);
    capture(12);
    check_display("v105", 105);
  endtask

  task automatic test_back_to_back();
    int acc, w, dn;
    logic [3:0] mid[3];
    acc = 0; w = 0; dn = 0;
    for (int d = 0; d < 3; d++) mid[d] = 'x;
    tick();
    in_valid = 1'b1; in_data = 8'd37;
    while (w < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      w++;
    end
    @(posedge clk); #1;
    in_data = 8'd200;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && acc == 0) acc = c;
      if (c >= 11 && c <= 13) begin
        case (b_digit_sel)
          3'b001: mid[0] = b_digit_val;
          3'b010: mid[1] = b_digit_val;
          3'b100: mid[2] = b_digit_val;
          default: ;
        endcase
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (acc != 10) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want 10", acc); end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (mid[d] !== ref_digit(37, d)) begin n_fail++; $display("FAIL b2b_first_digit%0d: got %0d want %0d", d, mid[d], ref_digit(37, d)); end
    end
    for (int k = 0; k < 20 && dn == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) dn = 1;
    end
    n_checks++; if (dn != 1) begin n_fail++; $display("FAIL b2b_second_done: got %0d want 1", dn); end
    capture(12);
    check_display("b2b_second", 200);
    n_checks++; if (cap_done_cnt != 0) begin n_fail++; $display("FAIL b2b_no_requeue: done pulses %0d want 0", cap_done_cnt); end
  endtask

  task automatic test_reset_abort();
    int lat, bad, w; bit rdy;
    w = 0;
    convert(8'd123, 1'b0, lat, bad, rdy);
    tick();
    in_valid = 1'b1; in_data = 8'd200;
    while (w < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_during_rst: ready=%b busy=%b done=%b want 000", in_ready, busy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_after_ctl: ready=%b busy=%b done=%b want 100", in_ready, busy, done); end
    n_checks++; if (digit_sel !== 3'b001 || b_digit_sel !== 3'b001) begin n_fail++; $display("FAIL abort_after_sel: got %b/%b want 001", digit_sel, b_digit_sel); end
    n_checks++; if (digit_val !== 4'd0 || digit_blank !== 1'b0) begin n_fail++; $display("FAIL abort_after_val: got %0d/%b want 0/0", digit_val, digit_blank); end
    capture(12);
    check_display("abort_cleared", 0);
    n_checks++; if (cap_done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: done pulses %0d want 0", cap_done_cnt); end
    convert(8'd99, 1'b0, lat, bad, rdy);
    n_checks++; if (lat != 9 || bad != 0 || !rdy) begin n_fail++; $display("FAIL abort_next_conv: lat=%0d bad=%0d rdy=%b want 9/0/1", lat, bad, rdy); end
    capture(12);
    check_display("abort_next", 99);
  endtask

  task automatic test_scan();
    logic [7:0] v;
    logic [2:0] exp_a, exp_b;
    v = 8'($urandom);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 24; j++) begin
      if (j == 5) begin in_valid = 1'b1; in_data = v; end
      if (j == 6) in_valid = 1'b0;
      @(negedge clk);
      exp_a = 3'(1 << ((j / 4) % 3));
      exp_b = 3'(1 << (j % 3));
      n_checks++;
      if (digit_sel !== exp_a || b_digit_sel !== exp_b) begin
        n_fail++;
        $display("FAIL scan_j%0d: got %b/%b want %b/%b", j, digit_sel, b_digit_sel, exp_a, exp_b);
      end
      @(posedge clk); #1;
    end
    capture(12);
    check_display("scan_conv", int'(v));
  endtask

  task automatic test_sweep();
    int order[256];
    int lat, bad, j, t; bit rdy;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      convert(8'(order[i]), 1'b1, lat, bad, rdy);
      n_checks++;
      if (lat != 9 || bad != 0 || !rdy) begin
        n_fail++;
        $display("FAIL sweep_timing v=%0d: lat=%0d bad=%0d rdy=%b want 9/0/1", order[i], lat, bad, rdy);
      end
      capture(12);
      check_display("sweep", order[i]);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero_blank();
    test_back_to_back();
    test_reset_abort();
    test_scan();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
